// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: receive side of the serial line protocol.
// Frame on the line input: start 0, then {byte, even parity} LSB-first (parity bit
// first, then byte bit 0..7), then stop 1. Good bytes are held until the
// consumer acknowledges with Ok; bad or unaccepted frames pulse a flag.
module serial_frame_receiver #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line,
  input  logic       Ok,
  output logic       data_available,
  output logic [7:0] output_data,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    BIT_LAST = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  // Frame word layout: bit 0 is the parity bit, bits 8:1 the byte.
  function automatic logic parity_ok(input logic [8:0] frame_bits);
    return frame_bits[0] == (^frame_bits[8:1]);
  endfunction

  state_t        state_r, state_nxt_s;
  logic [1:0]    sync_r;
  logic          line_s;
  logic [CW-1:0] clk_cnt_r;
  logic [3:0]    bit_idx_r;
  logic [8:0]    shift_r;
  logic          cnt_tick_s;
  logic          load_s, parity_err_nxt_s, frame_err_nxt_s, overrun_nxt_s;

  assign line_s = sync_r[1];

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], line};
    end
  end

  // Sample point: mid start bit while in START, end of bit period otherwise.
  always_comb begin
    cnt_tick_s = 1'b0;
    if (state_r == ST_START) begin
      cnt_tick_s = (clk_cnt_r == CNT_HALF);
    end else begin
      cnt_tick_s = (clk_cnt_r == CNT_LAST);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!line_s) state_nxt_s = ST_START;
        else         state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (cnt_tick_s) state_nxt_s = line_s ? ST_IDLE : ST_DATA;
        else            state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (cnt_tick_s && (bit_idx_r == BIT_LAST)) state_nxt_s = ST_STOP;
        else                                       state_nxt_s = ST_DATA;
      end
      ST_STOP: begin
        if (cnt_tick_s) state_nxt_s = line_s ? ST_IDLE : ST_WAIT_HIGH;
        else            state_nxt_s = ST_STOP;
      end
      ST_WAIT_HIGH: begin
        if (line_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_WAIT_HIGH;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: frame verdict at the stop-sample edge.
  always_comb begin
    load_s           = 1'b0;
    parity_err_nxt_s = 1'b0;
    frame_err_nxt_s  = 1'b0;
    overrun_nxt_s    = 1'b0;
    if ((state_r == ST_STOP) && cnt_tick_s) begin
      if (!line_s) begin
        frame_err_nxt_s = 1'b1;
      end else if (!parity_ok(shift_r)) begin
        parity_err_nxt_s = 1'b1;
      end else if (!data_available || Ok) begin
        load_s = 1'b1;
      end else begin
        overrun_nxt_s = 1'b1;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // Bit timing counters and data shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_r <= CNT_ZERO;
      bit_idx_r <= 4'd0;
      shift_r   <= 9'd0;
    end else begin
      case (state_r)
        ST_START, ST_STOP: begin
          clk_cnt_r <= cnt_tick_s ? CNT_ZERO : (clk_cnt_r + CNT_ONE);
          bit_idx_r <= 4'd0;
        end
        ST_DATA: begin
          if (cnt_tick_s) begin
            clk_cnt_r          <= CNT_ZERO;
            shift_r[bit_idx_r] <= line_s;
            bit_idx_r          <= (bit_idx_r == BIT_LAST) ? 4'd0 : (bit_idx_r + 4'd1);
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        default: begin
          clk_cnt_r <= CNT_ZERO;
          bit_idx_r <= 4'd0;
        end
      endcase
    end
  end

  // Holding register, handshake and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_available <= 1'b0;
      output_data    <= 8'h00;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      overrun        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      if (load_s) begin
        data_available <= 1'b1;
        output_data    <= shift_r[8:1];
      end else if (Ok) begin
        data_available <= 1'b0;
      end
      parity_err <= parity_err_nxt_s;
      frame_err  <= frame_err_nxt_s;
      overrun    <= overrun_nxt_s;
      busy       <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: the stimulus side predicts each
// frame's outcome from the protocol rules and queues it; a monitor pops and
// compares whenever the DUT reports a load or an error pulse.
module tb_serial_frame_receiver;
  localparam int B = 4;
  localparam int EV_DATA = 0, EV_PERR = 1, EV_FERR = 2, EV_OVR = 3;

  logic       clk = 1'b0, rst_n = 1'b1, line = 1'b1, Ok = 1'b0;
  logic       data_available, parity_err, frame_err, overrun, busy;
  logic [7:0] output_data;

  serial_frame_receiver #(.CLKS_PER_BIT(B)) dut (
    .clk(clk), .rst_n(rst_n), .line(line), .Ok(Ok),
    .data_available(data_available), .output_data(output_data),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; logic [7:0] data; } ev_t;
  ev_t exp_q[$];
  int  checks = 0, errors = 0, cyc = 0, last_load_cyc = 0, fall_cyc = 0;
  bit  hold_full = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input int kind, input logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none (t=%0t)", kind, data, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (e.kind == EV_DATA && kind == EV_DATA) check("event_data", 32'(data), 32'(e.data));
    end
  endtask

  // Monitor: a load is data_available high when it was low, or when Ok was high at the edge.
  initial begin
    logic prev_da, prev_ok;
    logic [7:0] prev_out;
    prev_da = 1'b0; prev_ok = 1'b0; prev_out = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_da = 1'b0; prev_ok = 1'b0; prev_out = 8'h00;
      end else begin
        if (parity_err) pop_check(EV_PERR, 8'h00);
        if (frame_err)  pop_check(EV_FERR, 8'h00);
        if (overrun)    pop_check(EV_OVR, 8'h00);
        if (data_available && (!prev_da || prev_ok)) begin
          pop_check(EV_DATA, output_data);
          last_load_cyc = cyc;
        end else if (data_available && prev_da) begin
          check("out_stable", 32'(output_data), 32'(prev_out));
        end
        prev_da = data_available; prev_ok = Ok; prev_out = output_data;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_ev(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.data = d;
    exp_q.push_back(e);
  endtask

  // Reference outcome of one frame from the protocol rules.
  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit ok_at_stop);
    if (bad_stop)                      push_ev(EV_FERR, 8'h00);
    else if (bad_par)                  push_ev(EV_PERR, 8'h00);
    else if (!hold_full || ok_at_stop) begin push_ev(EV_DATA, b); hold_full = 1'b1; end
    else                               push_ev(EV_OVR, 8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_da"},   32'(data_available), 32'd0);
    check({tag, "_out"},  32'(output_data),    32'd0);
    check({tag, "_perr"}, 32'(parity_err),     32'd0);
    check({tag, "_ferr"}, 32'(frame_err),      32'd0);
    check({tag, "_ovr"},  32'(overrun),        32'd0);
    check({tag, "_busy"}, 32'(busy),           32'd0);
  endtask

  // Drive one frame, starting right after a posedge; returns right after the last bit period.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int extra_low, input int abort_slot, input bit ok_stop, input bit ok_high);
    logic [10:0] bits;
    logic p;
    p = (^b) ^ bad_par;
    bits = {~bad_stop, b, p, 1'b0};
    if (abort_slot < 0) begin
      if (ok_high) hold_full = 1'b0;
      model_frame(b, bad_par, bad_stop, ok_stop | ok_high);
      if (ok_high) hold_full = 1'b0;
    end
    fall_cyc = cyc;
    for (int s = 0; s < 11; s++) begin
      line = bits[s];
      if (s == abort_slot) begin
        tick(2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_rst");
        tick(2);
        line = 1'b1;
        rst_n = 1'b1;
        hold_full = 1'b0;
        return;
      end
      tick(B);
    end
    if (bad_stop) begin
      tick(extra_low);
      if (extra_low >= 4) check("wait_high_busy", 32'(busy), 32'd1);
      line = 1'b1;
    end
    if (ok_stop) begin Ok = 1'b1; tick(1); Ok = 1'b0; end
  endtask

  task automatic ack();
    Ok = 1'b1; tick(1); Ok = 1'b0;
    hold_full = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    tick(3);
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;
    tick(3);

    // 0xA5: latency, value, single-cycle Ok clears.
    send_frame(8'hA5, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);
    tick(3);
    check("a5_latency", 32'(last_load_cyc - fall_cyc), 32'(3 + B / 2 + 10 * B));
    check("a5_da", 32'(data_available), 32'd1);
    check("a5_out", 32'(output_data), 32'hA5);
    ack();
    check("a5_ok_clears", 32'(data_available), 32'd0);

    // Bad parity, then good 0x3C.
    send_frame(8'h3C, 1'b1, 1'b0, 0, -1, 1'b0, 1'b0);
    tick(4);
    check("perr_no_da", 32'(data_available), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);
    tick(4);
    ack();

    // One-cycle glitch, then 0x55.
    line = 1'b0; tick(1); line = 1'b1;
    tick(8);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_no_da", 32'(data_available), 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);
    tick(4);
    ack();

    // Stop bit 0 with line held low for 30 more cycles.
    send_frame(8'h81, 1'b0, 1'b1, 30, -1, 1'b0, 1'b0);
    tick(4);
    check("ferr_recovered", 32'(busy), 32'd0);

    // Overrun, then same-edge Ok on the second stop sample.
    send_frame(8'h11, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);
    tick(3);
    send_frame(8'h22, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);
    tick(3);
    check("ovr_held_out", 32'(output_data), 32'h11);
    check("ovr_held_da", 32'(data_available), 32'd1);
    ack();
    send_frame(8'h11, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);
    tick(3);
    send_frame(8'h22, 1'b0, 1'b0, 0, -1, 1'b1, 1'b0);
    check("same_edge_da", 32'(data_available), 32'd1);
    check("same_edge_out", 32'(output_data), 32'h22);
    tick(3);
    ack();

    // Zero idle bits between frames, consumer always ready.
    Ok = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0, 0, -1, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b0, 0, -1, 1'b0, 1'b1);
    tick(3);
    Ok = 1'b0;
    tick(3);

    // Randomized frames, errors, glitches and consumer behaviour.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      int r, extra;
      bit mode1;
      b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      extra = $urandom_range(0, 30);
      mode1 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        line = 1'b0; tick(1); line = 1'b1; tick(6);
      end
      Ok = mode1;
      send_frame(b, r == 0, r == 1, extra, -1, 1'b0, mode1);
      tick(3);
      if (mode1) Ok = 1'b0;
      else if ($urandom_range(0, 1) == 1) ack();
      tick($urandom_range(0, 5));
    end
    ack();
    tick(3);

    // Reset during data bit 4 aborts the frame; next frame is clean.
    send_frame(8'h77, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);
    tick(3);
    send_frame(8'h99, 1'b0, 1'b0, 0, 5, 1'b0, 1'b0);
    tick(5);
    send_frame(8'h3E, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);
    tick(3);
    check("post_rst_da", 32'(data_available), 32'd1);
    check("post_rst_out", 32'(output_data), 32'h3E);
    ack();

    tick(10);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Synthesizable receive end of the serial port's line protocol. Recovers frames driven by the transmitter onto `line`: start bit 0, then 9 bits sent LSB-first as {byte, even-parity}, then stop bit 1. Checks parity and stop bit, then holds each good byte for downstream pickup via the `data_available`/`Ok` handshake. It replaces the delay-based receive path so the output side of the port can be built from clocked logic only.

## Interface
- `CLKS_PER_BIT`, default 4: `clk` cycles per bit on `line`. Must be even and ≥ 4.
- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  asynchronous, active-low reset.
- `line`  in  1  serial input; idles high; asynchronous to `clk`.
- `Ok`  in  1  consumer acknowledge; sampled on `clk`.
- `data_available`  out  1  holding register contains an unconsumed byte.
- `output_data`  out  8  received byte; valid while `data_available`=1.
- `parity_err`  out  1  one-cycle pulse: frame dropped on parity mismatch.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun`  out  1  one-cycle pulse: good frame dropped because the holding register was full.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- `line` passes through a 2-flop synchronizer to give `line_s`. All decisions use `line_s`.
- Counters:
  - `clk_cnt` counts 0..CLKS_PER_BIT-1.
  - `bit_idx` counts 0..8.
  - `shift` is a 9-bit register; bit *i* is the *i*-th received data bit.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when `line_s`=0, go to START and clear `clk_cnt`.
- START: increment `clk_cnt`. At `clk_cnt`=CLKS_PER_BIT/2-1, sample `line_s`.
  - If 0: go to DATA with `clk_cnt`=0 and `bit_idx`=0.
  - If 1: treat as a glitch and return to IDLE with no error.
- DATA: at `clk_cnt`=CLKS_PER_BIT-1, set `shift[bit_idx]`=`line_s` and clear `clk_cnt`.
  - After `bit_idx`=8 is captured, go to STOP.
- STOP: at `clk_cnt`=CLKS_PER_BIT-1, sample `line_s`. Byte is `shift[8:1]`, parity is `shift[0]`.
  - Stop bit 0: pulse `frame_err` (no parity check), go to WAIT_HIGH.
  - Else if `parity` ≠ XOR(`byte`): pulse `parity_err`, go to IDLE.
  - Else (good frame):
    - If the holding register is empty, or `Ok`=1 on this same edge: load `output_data`=`byte` and set `data_available`=1.
    - Otherwise: pulse `overrun` and keep the old byte.
    - Go to IDLE.
- WAIT_HIGH: stay until `line_s`=1, then go to IDLE. This stops a held-low line from being re-read as new frames.
- Handshake:
  - `data_available` rises on the edge that loads the byte.
  - It stays high until `Ok`=1 is sampled, then clears on that edge (unless a new good frame loads on the same edge).
  - `output_data` stays stable while `data_available`=1.
  - `Ok` while `data_available`=0 has no effect.
- Reset mid-frame aborts the frame; there is no partial delivery.

## Timing
- Reset values:
  - FSM = IDLE; counters = 0; `shift` = 0.
  - `data_available`=0, `output_data`=8'h00.
  - `parity_err`=`frame_err`=`overrun`=0, `busy`=0.
  - Synchronizer flops = 1.
- Input latency: a `line` change reaches `line_s` 2 edges later.
- With START entered at edge E, let B=CLKS_PER_BIT:
  - start-bit sample at E+B/2;
  - data bit *i* sampled at E+B/2+(i+1)·B;
  - stop sample at E+B/2+10·B.
- `data_available` and error pulses are registered at the stop-sample edge, so they are visible the following cycle.
- With B=4: 42 edges from entering START.
- Back-to-back frames (transmitter's 2 idle bits) and zero idle bits are both accepted. IDLE reacts on the first edge after STOP.
- `busy`=1 from START entry through the STOP/WAIT_HIGH exit.

## Test plan
- B=4, frame for 0xA5 (bits 0, p=0, 1,0,1,0,0,1,0,1, 1) -> `data_available`=1 at edge E+42; `output_data`=8'hA5; no error pulses. `Ok`=1 for one cycle -> `data_available`=0 next edge.
- 0x3C sent with parity bit 1 -> single `parity_err` pulse; `data_available` stays 0; next good 0x3C is received normally.
- `line` low for 1 `clk` cycle only -> returns to IDLE with no outputs changed; the following full frame of 0x55 is received correctly.
- 0x81 with stop bit 0, `line` then held low for 30 cycles -> one `frame_err` pulse; FSM stays in WAIT_HIGH; no extra frames; recovers after `line` goes high.
- Overrun and same-edge handshake:
  - Frames 0x11 then 0x22 with no `Ok` -> `output_data`=0x11 held; `overrun` pulses at the second stop sample.
  - Repeat with `Ok`=1 on the second stop-sample edge -> `output_data`=0x22; `data_available` stays 1; no `overrun`.
- Assert `rst_n`=0 during data bit 4 -> all outputs return to reset values immediately; a frame sent after release is received correctly.
